// File: rtl/switch_sched_if.sv
// Request/grant bundle between the four switch inputs and the output-port scheduler.
// The scheduler takes the slave side; the traffic sources take the master side.
interface switch_sched_if;
    logic [3:0] req_valid;
    logic [7:0] req_dst;
    logic [3:0] tx_last;
    logic [3:0] grant;
    logic [7:0] sel;
    logic [3:0] out_en;
    logic [3:0] timeout_err;

    modport master (
        output req_valid, req_dst, tx_last,
        input  grant, sel, out_en, timeout_err
    );

    modport slave (
        input  req_valid, req_dst, tx_last,
        output grant, sel, out_en, timeout_err
    );
endinterface

// File: rtl/switch_sched.sv
// 4x4 crossbar scheduler: each output port runs its own round-robin IDLE/CONN FSM,
// with an optional hold timeout that force-releases a stuck connection.
module switch_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    switch_sched_if.slave  bus
);
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONN = 1'b1
    } state_t;

    state_t          state_q [N];
    state_t          state_d [N];
    logic [IW-1:0]   ptr_q   [N];
    logic [IW-1:0]   ptr_d   [N];
    logic [IW-1:0]   owner_q [N];
    logic [IW-1:0]   owner_d [N];
    logic [CW-1:0]   cnt_q   [N];
    logic [CW-1:0]   cnt_d   [N];
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    out_en_q, out_en_d;
    logic [N-1:0]    terr_q, terr_d;
    logic [2*N-1:0]  sel_q, sel_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            rel;
    logic            tmo;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N; j++) begin
                state_q[j] <= IDLE;
                ptr_q[j]   <= '0;
                owner_q[j] <= '0;
                cnt_q[j]   <= '0;
            end
            grant_q  <= '0;
            out_en_q <= '0;
            terr_q   <= '0;
            sel_q    <= '0;
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                state_q[j] <= state_d[j];
                ptr_q[j]   <= ptr_d[j];
                owner_q[j] <= owner_d[j];
                cnt_q[j]   <= cnt_d[j];
            end
            grant_q  <= grant_d;
            out_en_q <= out_en_d;
            terr_q   <= terr_d;
            sel_q    <= sel_d;
        end
    end

    // Per-output arbitration, release and timeout; candidacy uses the registered grant
    always_comb begin
        grant_d  = '0;
        out_en_d = '0;
        terr_d   = '0;
        sel_d    = sel_q;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        rel      = 1'b0;
        tmo      = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            state_d[j] = state_q[j];
            ptr_d[j]   = ptr_q[j];
            owner_d[j] = owner_q[j];
            cnt_d[j]   = cnt_q[j];
            found      = 1'b0;
            win        = '0;
            rel        = 1'b0;
            tmo        = 1'b0;
            case (state_q[j])
                IDLE: begin
                    for (int unsigned k = 0; k < N; k++) begin
                        idx = ptr_q[j] + IW'(k);
                        if (!found && bus.req_valid[idx] && !grant_q[idx] &&
                            (bus.req_dst[{idx, 1'b0} +: 2] == IW'(j))) begin
                            found = 1'b1;
                            win   = idx;
                        end
                    end
                    if (found) begin
                        state_d[j]         = CONN;
                        owner_d[j]         = win;
                        sel_d[2*j +: 2]    = win;
                        ptr_d[j]           = win + IW'(1);
                        cnt_d[j]           = '0;
                    end
                end
                CONN: begin
                    rel = bus.tx_last[owner_q[j]];
                    tmo = (TIMEOUT != 0) && ((32'(cnt_q[j]) + 32'd1) >= TIMEOUT);
                    if (rel || tmo) begin
                        state_d[j] = IDLE;
                        terr_d[j]  = tmo && !rel;
                    end
                    // Saturating hold counter; frozen when the timeout is disabled
                    if ((TIMEOUT != 0) && !rel && (32'(cnt_q[j]) < TIMEOUT)) begin
                        cnt_d[j] = cnt_q[j] + CW'(1);
                    end
                end
                default: state_d[j] = IDLE;
            endcase
            out_en_d[j] = (state_d[j] == CONN);
            if (state_d[j] == CONN) begin
                grant_d[owner_d[j]] = 1'b1;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.out_en      = out_en_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: doc/switch_sched.md
SWITCH_SCHED -- requirements
Module: switch_sched

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles one connection may hold an output port. 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  4  bit i: input port i requests a connection.
REQ-005 req_dst  input  8  bits [2i+1:2i]: destination output port requested by input i.
REQ-006 tx_last  input  4  bit i: final beat of input i's current transfer.
REQ-007 grant  output  4  bit i: input i is connected to an output port.
REQ-008 sel  output  8  bits [2j+1:2j]: source input index for output j's mux; drives the 4x4 switch sel bus directly.
REQ-009 out_en  output  4  bit j: output j carries a granted connection, so port_rx[j] is valid.
REQ-010 timeout_err  output  4  bit j: one-cycle pulse when output j's connection is force-released.

Function
REQ-011 Each output j SHALL run an independent two-state FSM with states IDLE and CONN.
REQ-012 Each output j SHALL hold a 2-bit round-robin pointer ptr[j], a 2-bit owner[j] and a timeout counter.
REQ-013 Input i is a candidate for output j when req_valid[i]=1, req_dst[2i+1:2i]=j and grant[i]=0.
REQ-014 On each edge in IDLE with at least one candidate, output j SHALL select the first candidate in the order ptr[j], ptr[j]+1, ... (mod 4).
REQ-015 On that selection edge, output j SHALL:
- set owner[j] to the winner;
- set sel[2j+1:2j] to the winner;
- set grant[winner] and out_en[j] to 1;
- set ptr[j] to winner+1 mod 4;
- clear its timeout counter;
- enter CONN.
REQ-016 Grant latency: a request sampled at edge n is reflected in grant and sel after edge n. Outputs are registered with no combinational path from inputs.
REQ-017 In CONN, the release edge is the edge at which tx_last[owner[j]]=1 is sampled. At that edge, output j SHALL clear grant[owner[j]] and out_en[j] and return to IDLE.
REQ-018 In IDLE, sel[2j+1:2j] SHALL keep its last value.
REQ-019 Minimum gap between connections on one output SHALL be one cycle: no re-arbitration occurs on the release edge.
REQ-020 In CONN, changes to req_valid and req_dst of the owner SHALL be ignored; only tx_last or a timeout releases the connection.
REQ-021 tx_last from an input that is not granted SHALL be ignored.
REQ-022 With TIMEOUT>0, the counter SHALL increment each CONN cycle without release. When it reaches TIMEOUT, output j SHALL:
- release as in REQ-017;
- assert timeout_err[j] for exactly one cycle.
REQ-023 If tx_last and timeout occur on the same edge, the release SHALL be treated as normal and timeout_err[j] SHALL stay 0.
REQ-024 The timeout counter SHALL saturate at TIMEOUT. Its width is clog2(TIMEOUT+1), minimum 1.
REQ-025 Each input SHALL be granted to at most one output. grant SHALL equal the OR over outputs in CONN of onehot(owner[j]).
REQ-026 Different outputs SHALL be able to grant different inputs on the same edge.

Reset
REQ-027 While rst_n=0, all of the following SHALL be 0:
- grant, sel, out_en, timeout_err;
- every ptr, owner and timeout counter.
All FSMs SHALL be in IDLE.
REQ-028 Reset asserted mid-connection SHALL drop every connection immediately and asynchronously, with no timeout_err pulse.
REQ-029 After rst_n rises, the first arbitration SHALL occur on the first clock edge.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Single request: req_valid=0001, req_dst=00 -> after the next edge grant=0001, out_en=0001, sel[1:0]=0. tx_last[0] pulse -> grant=0, out_en=0 after that edge.
- Contention: inputs 0, 1 and 3 all target output 2, held continuously, each with a 2-beat transfer. Grants go to 0, then 1, then 3 (ptr 0->1->2->0). Exactly one idle cycle between connections. sel[5:4] sequence is 0, 1, 3.
- Full permutation: req_dst = {0,1,2,3} reversed, i.e. input i->3-i -> after one edge out_en=1111, grant=1111, sel=8'b00_01_10_11.
- Timeout: TIMEOUT=4, input 2->output 1, tx_last never asserted -> out_en[1] high for 4 cycles, then timeout_err=0010 for one cycle and grant[2]=0. Simultaneous tx_last on the 4th cycle -> no timeout_err.
- Reset mid-operation: rst_n=0 while 3 outputs are in CONN -> all outputs 0 without a clock. After release, a requester with ptr reset to 0 wins first.
- Ignored inputs: tx_last on a non-granted input, and req_dst changed by the owner during CONN -> no change to grant, sel or out_en.
